// File: rtl/line_xfer_engine.sv
// Cache-line transfer sequencer: optional victim write-back, then optional four-word fill into the cache.
// One word issue per cycle when its bank is free and memory is not stalled; done pulses after the last fill return.
module line_xfer_engine #(
   parameter int DATA_W  = 16,
   parameter int TAG_W   = 5,
   parameter int INDEX_W = 8,
   parameter int RD_LAT  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     do_wb,
   input  logic                     do_fill,
   input  logic [INDEX_W-1:0]       index,
   input  logic [TAG_W-1:0]         wb_tag,
   input  logic [TAG_W-1:0]         fill_tag,
   input  logic [DATA_W-1:0]        cache_data_out,
   output logic [1:0]               cache_offset,
   output logic [DATA_W-1:0]        cache_data_in,
   output logic                     cache_wr,
   output logic [TAG_W+INDEX_W+2:0] mem_addr,
   output logic [DATA_W-1:0]        mem_data_in,
   output logic                     mem_wr,
   output logic                     mem_rd,
   input  logic [DATA_W-1:0]        mem_data_out,
   input  logic [3:0]               mem_busy,
   input  logic                     mem_stall,
   input  logic                     mem_err,
   output logic                     xfer_busy,
   output logic                     done,
   output logic                     err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WB,
      S_FILL_ISSUE,
      S_DRAIN,
      S_DONE,
      S_ERR
   } state_t;

   state_t state, state_nxt;

   logic [1:0]               k;
   logic [INDEX_W-1:0]       index_q;
   logic [TAG_W-1:0]         wb_tag_q;
   logic [TAG_W-1:0]         fill_tag_q;
   logic                     do_fill_q;

   logic [RD_LAT-1:0]        pipe_vld;
   logic [RD_LAT-1:0][1:0]   pipe_off;
   logic [RD_LAT-1:0]        pipe_live;

   logic start_ok;
   logic issue_ok;
   logic wb_issue;
   logic rd_issue;
   logic err_abort;
   logic ret_vld;
   logic [1:0] ret_off;
   logic pipe_pend;

   assign start_ok  = (state == S_IDLE) && start;
   assign issue_ok  = !mem_stall && !mem_busy[k];
   assign wb_issue  = (state == S_WB) && issue_ok;
   assign rd_issue  = (state == S_FILL_ISSUE) && issue_ok;
   assign err_abort = mem_err && (state inside {S_WB, S_FILL_ISSUE, S_DRAIN});
   assign ret_vld   = pipe_vld[RD_LAT-1];
   assign ret_off   = pipe_off[RD_LAT-1];

   // Entries still in flight after the one maturing this cycle; DRAIN leaves once none remain.
   always_comb begin
      pipe_live = pipe_vld;
      pipe_live[RD_LAT-1] = 1'b0;
      pipe_pend = |pipe_live;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               if (do_wb)        state_nxt = S_WB;
               else if (do_fill) state_nxt = S_FILL_ISSUE;
               else              state_nxt = S_DONE;
            end
         end
         S_WB: begin
            if (wb_issue && (k == 2'd3)) state_nxt = do_fill_q ? S_FILL_ISSUE : S_DONE;
         end
         S_FILL_ISSUE: begin
            if (rd_issue && (k == 2'd3)) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (!pipe_pend) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (err_abort) state_nxt = S_ERR;
   end

   always_comb begin
      cache_offset  = 2'd0;
      cache_data_in = '0;
      cache_wr      = ret_vld;
      mem_addr      = '0;
      mem_data_in   = '0;
      mem_wr        = 1'b0;
      mem_rd        = 1'b0;
      xfer_busy     = (state != S_IDLE);
      done          = 1'b0;
      err           = 1'b0;
      unique case (state)
         S_WB: begin
            cache_offset = k;
            mem_addr     = {wb_tag_q, index_q, k, 1'b0};
            mem_data_in  = cache_data_out;
            mem_wr       = issue_ok;
         end
         S_FILL_ISSUE: begin
            mem_addr = {fill_tag_q, index_q, k, 1'b0};
            mem_rd   = issue_ok;
         end
         S_DONE: begin
            done = 1'b1;
         end
         S_ERR: begin
            done = 1'b1;
            err  = 1'b1;
         end
         default: begin
         end
      endcase
      // A maturing return owns the cache port, even while later reads are still issuing.
      if (ret_vld) begin
         cache_offset  = ret_off;
         cache_data_in = mem_data_out;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k          <= 2'd0;
         index_q    <= '0;
         wb_tag_q   <= '0;
         fill_tag_q <= '0;
         do_fill_q  <= 1'b0;
      end else if (start_ok) begin
         k          <= 2'd0;
         index_q    <= index;
         wb_tag_q   <= wb_tag;
         fill_tag_q <= fill_tag;
         do_fill_q  <= do_fill;
      end else if (wb_issue || rd_issue) begin
         k <= k + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld <= '0;
         pipe_off <= '0;
      end else if (err_abort) begin
         pipe_vld <= '0;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_off[i] <= pipe_off[i-1];
         end
         pipe_vld[0] <= rd_issue;
         pipe_off[0] <= k;
      end
   end

endmodule

// File: tb/tb_line_xfer_engine.sv
// Directed bench for line_xfer_engine: expected memory issues, cache writes and done pulses are queued
// at stimulus time and popped as the design produces them, each with its required cycle.
module tb_line_xfer_engine;

   localparam int DATA_W  = 16;
   localparam int TAG_W   = 5;
   localparam int INDEX_W = 8;
   localparam int RD_LAT  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, do_wb, do_fill;
   logic [7:0]  index;
   logic [4:0]  wb_tag, fill_tag;
   logic [15:0] cache_data_out;
   logic [1:0]  cache_offset;
   logic [15:0] cache_data_in;
   logic        cache_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_data_in;
   logic        mem_wr, mem_rd;
   logic [15:0] mem_data_out;
   logic [3:0]  mem_busy;
   logic        mem_stall, mem_err;
   logic        xfer_busy, done, err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] cyc;
   } mem_ev_t;

   typedef struct packed {
      logic [1:0]  off;
      logic [15:0] data;
      logic [15:0] cyc;
   } cache_ev_t;

   typedef struct packed {
      logic        err;
      logic [15:0] cyc;
   } done_ev_t;

   mem_ev_t   mem_q[$];
   cache_ev_t cache_q[$];
   done_ev_t  done_q[$];

   always #5 clk = ~clk;

   line_xfer_engine #(
      .DATA_W(DATA_W), .TAG_W(TAG_W), .INDEX_W(INDEX_W), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .do_wb(do_wb), .do_fill(do_fill),
      .index(index), .wb_tag(wb_tag), .fill_tag(fill_tag),
      .cache_data_out(cache_data_out), .cache_offset(cache_offset),
      .cache_data_in(cache_data_in), .cache_wr(cache_wr),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr(mem_wr), .mem_rd(mem_rd),
      .mem_data_out(mem_data_out), .mem_busy(mem_busy), .mem_stall(mem_stall),
      .mem_err(mem_err), .xfer_busy(xfer_busy), .done(done), .err(err)
   );

   function automatic logic [15:0] cdat(input logic [1:0] off);
      return 16'hCA50 | {14'd0, off};
   endfunction

   function automatic logic [15:0] mdat(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] maddr(input logic [4:0] tag, input logic [7:0] idx, input logic [1:0] k);
      return {tag, idx, k, 1'b0};
   endfunction

   assign cache_data_out = cdat(cache_offset);

   // Memory model: read data appears RD_LAT cycles after the issuing cycle.
   logic [15:0] rq_addr [RD_LAT];
   logic        rq_vld  [RD_LAT];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            rq_vld[i]  <= 1'b0;
            rq_addr[i] <= 16'h0;
         end
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            rq_vld[i]  <= rq_vld[i-1];
            rq_addr[i] <= rq_addr[i-1];
         end
         rq_vld[0]  <= mem_rd;
         rq_addr[0] <= mem_addr;
      end
   end
   assign mem_data_out = rq_vld[RD_LAT-1] ? mdat(rq_addr[RD_LAT-1]) : 16'hDEAD;

   always @(posedge clk) cyc <= cyc + 1;

   mem_ev_t   mobs, mexp;
   cache_ev_t cobs, cexp;
   done_ev_t  dobs, dexp;

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_wr || mem_rd) begin
            checks = checks + 1;
            assert (!(mem_wr && mem_rd) && !mem_stall) else begin
               errors = errors + 1;
               $error("FAIL issue_legal got wr=%b rd=%b stall=%b want single issue without stall", mem_wr, mem_rd, mem_stall);
            end
            checks = checks + 1;
            assert (mem_q.size() > 0) else begin
               errors = errors + 1;
               $error("FAIL mem_extra got wr=%b rd=%b addr=%h at cyc %0d want no issue", mem_wr, mem_rd, mem_addr, cyc);
            end
            if (mem_q.size() > 0) begin
               mexp = mem_q.pop_front();
               mobs.wr = mem_wr;
               mobs.addr = mem_addr;
               mobs.data = mem_wr ? mem_data_in : 16'h0;
               mobs.cyc = 16'(cyc);
               checks = checks + 1;
               assert (mobs === mexp) else begin
                  errors = errors + 1;
                  $error("FAIL mem_issue got wr=%b addr=%h data=%h cyc=%0d want wr=%b addr=%h data=%h cyc=%0d",
                         mobs.wr, mobs.addr, mobs.data, mobs.cyc, mexp.wr, mexp.addr, mexp.data, mexp.cyc);
               end
            end
         end
         if (cache_wr) begin
            checks = checks + 1;
            assert (cache_q.size() > 0) else begin
               errors = errors + 1;
               $error("FAIL cache_extra got off=%0d data=%h at cyc %0d want no cache write", cache_offset, cache_data_in, cyc);
            end
            if (cache_q.size() > 0) begin
               cexp = cache_q.pop_front();
               cobs.off = cache_offset;
               cobs.data = cache_data_in;
               cobs.cyc = 16'(cyc);
               checks = checks + 1;
               assert (cobs === cexp) else begin
                  errors = errors + 1;
                  $error("FAIL cache_write got off=%0d data=%h cyc=%0d want off=%0d data=%h cyc=%0d",
                         cobs.off, cobs.data, cobs.cyc, cexp.off, cexp.data, cexp.cyc);
               end
            end
         end
         if (done) begin
            checks = checks + 1;
            assert (done_q.size() > 0) else begin
               errors = errors + 1;
               $error("FAIL done_extra got done at cyc %0d want none", cyc);
            end
            if (done_q.size() > 0) begin
               dexp = done_q.pop_front();
               dobs.err = err;
               dobs.cyc = 16'(cyc);
               checks = checks + 1;
               assert (dobs === dexp) else begin
                  errors = errors + 1;
                  $error("FAIL done_pulse got err=%b cyc=%0d want err=%b cyc=%0d", dobs.err, dobs.cyc, dexp.err, dexp.cyc);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wb(input logic [4:0] tag, input logic [7:0] idx, input int first);
      mem_ev_t e;
      for (int k = 0; k < 4; k++) begin
         e.wr = 1'b1;
         e.addr = maddr(tag, idx, 2'(k));
         e.data = cdat(2'(k));
         e.cyc = 16'(first + k);
         mem_q.push_back(e);
      end
   endtask

   // Reads in cycles first, first+1, then words 2/3 delayed by 'gap' cycles.
   task automatic push_fill(input logic [4:0] tag, input logic [7:0] idx, input int first, input int gap);
      mem_ev_t e;
      cache_ev_t c;
      int rc;
      for (int k = 0; k < 4; k++) begin
         rc = first + k + ((k >= 2) ? gap : 0);
         e.wr = 1'b0;
         e.addr = maddr(tag, idx, 2'(k));
         e.data = 16'h0;
         e.cyc = 16'(rc);
         mem_q.push_back(e);
         c.off = 2'(k);
         c.data = mdat(e.addr);
         c.cyc = 16'(rc + RD_LAT);
         cache_q.push_back(c);
      end
   endtask

   task automatic push_done(input logic e, input int c);
      done_ev_t d;
      d.err = e;
      d.cyc = 16'(c);
      done_q.push_back(d);
   endtask

   task automatic req(input logic wb, input logic fill, input logic [7:0] idx,
                      input logic [4:0] wtag, input logic [4:0] ftag);
      start = 1'b1;
      do_wb = wb;
      do_fill = fill;
      index = idx;
      wb_tag = wtag;
      fill_tag = ftag;
   endtask

   task automatic unreq();
      start = 1'b0;
      do_wb = 1'b1;
      do_fill = 1'b0;
      index = 8'hEE;
      wb_tag = 5'h0E;
      fill_tag = 5'h11;
   endtask

   task automatic chk_zero(input string tag);
      @(negedge clk);
      checks = checks + 1;
      assert ({xfer_busy, done, err, cache_wr, mem_wr, mem_rd, cache_offset, mem_addr, mem_data_in, cache_data_in} === 56'h0) else begin
         errors = errors + 1;
         $error("FAIL %s got busy=%b done=%b err=%b cwr=%b mwr=%b mrd=%b off=%0d addr=%h mdi=%h cdi=%h want all zero",
                tag, xfer_busy, done, err, cache_wr, mem_wr, mem_rd, cache_offset, mem_addr, mem_data_in, cache_data_in);
      end
   endtask

   task automatic wait_idle(input string tag, input int max_cycles);
      for (int i = 0; i < max_cycles && (mem_q.size() + cache_q.size() + done_q.size()) > 0; i++) tick();
      checks = checks + 1;
      assert ((mem_q.size() + cache_q.size() + done_q.size()) == 0) else begin
         errors = errors + 1;
         $error("FAIL %s_timeout got pending mem=%0d cache=%0d done=%0d want 0", tag, mem_q.size(), cache_q.size(), done_q.size());
      end
      @(negedge clk);
      checks = checks + 1;
      assert (xfer_busy === 1'b0) else begin
         errors = errors + 1;
         $error("FAIL %s_idle got xfer_busy=%b want 0", tag, xfer_busy);
      end
      repeat (3) tick();
   endtask

   int c0;

   initial begin
      rst = 1'b1;
      mem_busy = 4'h0;
      mem_stall = 1'b0;
      mem_err = 1'b0;
      unreq();
      tick();
      chk_zero("reset_outputs");
      tick();
      rst = 1'b0;
      tick();

      // Fill only, nominal timing.
      c0 = cyc;
      req(1'b0, 1'b1, 8'h12, 5'h15, 5'h03);
      push_fill(5'h03, 8'h12, c0 + 1, 0);
      push_done(1'b0, c0 + 7);
      tick();
      unreq();
      wait_idle("fill_only", 30);

      // Write-back then fill.
      c0 = cyc;
      req(1'b1, 1'b1, 8'h00, 5'h1F, 5'h02);
      push_wb(5'h1F, 8'h00, c0 + 1);
      push_fill(5'h02, 8'h00, c0 + 5, 0);
      push_done(1'b0, c0 + 11);
      tick();
      unreq();
      wait_idle("wb_fill", 40);

      // Bank 2 busy for three extra cycles.
      c0 = cyc;
      req(1'b0, 1'b1, 8'hA5, 5'h00, 5'h07);
      mem_busy = 4'b0100;
      push_fill(5'h07, 8'hA5, c0 + 1, 3);
      push_done(1'b0, c0 + 10);
      tick();
      unreq();
      repeat (5) tick();
      mem_busy = 4'h0;
      wait_idle("bank_busy", 40);

      // Memory error while word 1 read issues.
      c0 = cyc;
      req(1'b0, 1'b1, 8'h3C, 5'h00, 5'h0C);
      push_fill(5'h0C, 8'h3C, c0 + 1, 0);
      void'(mem_q.pop_back());
      void'(mem_q.pop_back());
      cache_q.delete();
      push_done(1'b1, c0 + 3);
      tick();
      unreq();
      tick();
      mem_err = 1'b1;
      tick();
      mem_err = 1'b0;
      wait_idle("mem_err", 20);

      // Empty request completes next cycle.
      c0 = cyc;
      req(1'b0, 1'b0, 8'h77, 5'h01, 5'h02);
      push_done(1'b0, c0 + 1);
      tick();
      unreq();
      wait_idle("no_op", 10);

      // Second start during a transfer is ignored.
      c0 = cyc;
      req(1'b0, 1'b1, 8'h34, 5'h00, 5'h0A);
      push_fill(5'h0A, 8'h34, c0 + 1, 0);
      push_done(1'b0, c0 + 7);
      tick();
      unreq();
      tick();
      req(1'b1, 1'b1, 8'hFF, 5'h1F, 5'h1F);
      tick();
      unreq();
      wait_idle("busy_start", 30);

      // Reset during write-back at word 2, then a clean transfer.
      c0 = cyc;
      req(1'b1, 1'b1, 8'h5A, 5'h11, 5'h06);
      push_wb(5'h11, 8'h5A, c0 + 1);
      void'(mem_q.pop_back());
      void'(mem_q.pop_back());
      tick();
      unreq();
      tick();
      tick();
      rst = 1'b1;
      chk_zero("reset_mid_wb");
      tick();
      rst = 1'b0;
      tick();
      c0 = cyc;
      req(1'b1, 1'b1, 8'h5A, 5'h11, 5'h06);
      push_wb(5'h11, 8'h5A, c0 + 1);
      push_fill(5'h06, 8'h5A, c0 + 5, 0);
      push_done(1'b0, c0 + 11);
      tick();
      unreq();
      wait_idle("after_reset", 40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
